fxyz_equiv_ctrl: RTL
====================

# fxyz_equiv_ctrl

Sequencing controller that drives the three inputs (x, y, z) of a two-output boolean evaluator through all 8 truth-table rows, samples both outputs (s1 = unsimplified form, s2 = simplified form) and reports whether the two expressions are equivalent. It replaces the hand-written `#1` stimulus list with a clocked, self-checking sweep. It sits between a start/result interface and any `fxyz`-style combinational evaluator, with x/y/z wired out and s1/s2 wired back.

## Interface
- SETTLE, 1: cycles x/y/z are held before s1/s2 are sampled; legal range 1..15.

- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- s1  input  1  evaluator output, unsimplified expression.
- s2  input  1  evaluator output, simplified expression.
- x, y, z  output  1 each  registered evaluator inputs; {x,y,z} = row index, x is the MSB.
- busy  output  1  high from the cycle after start is accepted through the last SAMPLE.
- done  output  1  one-cycle pulse when the sweep ends.
- equal  output  1  1 when the last completed sweep had zero mismatches; held until the next accepted start.
- mismatch_count  output  4  number of mismatching rows (0..8).
- first_fail  output  3  index of the first mismatching row; 0 if none.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: x=y=z=0, busy=0. If start=1: clear mismatch_count, first_fail and equal; set row=0; load the settle counter with SETTLE-1; go to SETTLE.
- SETTLE: {x,y,z}=row. Decrement the counter. When it reaches 0, go to SAMPLE.
- SAMPLE: mismatch is `s1 !== s2` (4-state, so X or Z counts as a mismatch).
  - On mismatch: increment mismatch_count; if the count was 0, set first_fail=row.
  - If row==7, go to DONE. Otherwise row+1, reload the counter, go to SETTLE.
- DONE: done=1 for exactly this cycle; equal = (final mismatch_count==0). Next state is IDLE.
- start is ignored outside IDLE, including in DONE.
- mismatch_count, first_fail and equal keep their values in IDLE until the next accepted start.
- Reset values: x=y=z=0, busy=0, done=0, equal=0, mismatch_count=0, first_fail=0, state=IDLE, row=0.
- rst has priority over every other event. Reset mid-sweep aborts on the next edge with no done pulse.

## Timing
- Start accepted at edge 0. First row is driven from edge 1.
- Each row takes SETTLE+1 cycles.
- done is high in the cycle after edge 1+8·(SETTLE+1) (edge 17 for SETTLE=1).
- A new start is accepted one cycle after done, at the earliest.
- Outputs are registered and have no combinational path from s1/s2. The first SAMPLE after reset sees at least SETTLE cycles of stable inputs.
- busy=1 in SETTLE and SAMPLE only.

## Configuration
- EQUIV_STOP_ON_FAIL_EN
  - Defined: the first mismatch in SAMPLE goes straight to DONE. mismatch_count is then 1, first_fail is that row, equal=0, and the rest of the sweep is skipped.
  - Undefined: all 8 rows are always evaluated and mismatch_count is the full total.

## Test plan
- Evaluator s1=~(~x&~y)&(x|y), s2=x|y, SETTLE=1, macro undefined; start at edge 0 -> done at edge 17, equal=1, mismatch_count=0, first_fail=0. x/y/z step 000..111, each held 2 cycles.
- Faulty evaluator s2=x&y, macro undefined -> mismatches on rows 2,3,4,5; mismatch_count=4, first_fail=3'b010, equal=0, done at edge 17.
- Same faulty evaluator, EQUIV_STOP_ON_FAIL_EN defined -> row 2 sampled at edge 6, done at edge 7, mismatch_count=1, first_fail=3'b010.
- SETTLE=3, equivalent evaluator -> each row held 4 cycles, done at edge 33, equal=1.
- start re-asserted while busy, and rst asserted at edge 9 during the sweep:
  - the extra start is ignored;
  - after rst, all outputs return to reset values at edge 10 with no done pulse;
  - a new start at edge 12 runs a full sweep to done at edge 29.
- Evaluator s2 driven to 1'bx on row 5 only -> counted as a mismatch; mismatch_count=1, first_fail=3'b101.

Source files
------------

// File: rtl/fxyz_equiv_ctrl.sv
// Sweeps x/y/z through all 8 rows of a two-output evaluator and reports whether s1 and s2 agree.
// Optional build macro EQUIV_STOP_ON_FAIL_EN: end the sweep at the first mismatching row.
module fxyz_equiv_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       s1,
  input  logic       s2,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       equal,
  output logic [3:0] mismatch_count,
  output logic [2:0] first_fail
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ROW_W = 3;
  localparam int unsigned MC_W  = 4;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] xyz_q, xyz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             equal_q, equal_d;
  logic [MC_W-1:0]  mcount_q, mcount_d;
  logic [ROW_W-1:0] ffail_q, ffail_d;
  logic             row_fail;

  // 4-state compare so an X or Z from the evaluator is a mismatch
  assign row_fail = (s1 !== s2);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      cnt_q    <= '0;
      xyz_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      equal_q  <= 1'b0;
      mcount_q <= '0;
      ffail_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      xyz_q    <= xyz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      equal_q  <= equal_d;
      mcount_q <= mcount_d;
      ffail_q  <= ffail_d;
    end
  end

  // Next state; outputs are derived from the next state so they register alongside it
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    mcount_d = mcount_q;
    ffail_d  = ffail_q;
    equal_d  = equal_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    xyz_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcount_d = '0;
          ffail_d  = '0;
          equal_d  = 1'b0;
          row_d    = '0;
          // Row 0 gets one extra cycle: x/y/z only leave the idle value at this edge
          cnt_d    = CNT_W'(SETTLE);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (row_fail) begin
          mcount_d = mcount_q + MC_W'(1);
          if (mcount_q == '0) begin
            ffail_d = row_q;
          end
        end
`ifdef EQUIV_STOP_ON_FAIL_EN
        if (row_fail || (row_q == ROW_LAST)) begin
`else
        if (row_q == ROW_LAST) begin
`endif
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    xyz_d  = busy_d ? row_d : '0;
    if (state_d == ST_DONE) begin
      equal_d = (mcount_d == '0);
    end
  end

  assign {x, y, z}      = xyz_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign equal          = equal_q;
  assign mismatch_count = mcount_q;
  assign first_fail     = ffail_q;

endmodule
